// File: rtl/adc_capture_pkg.sv
// Shared types and helpers for the ADC capture controller.
package adc_capture_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DRAIN
    } state_e;

    // FIFO entry layout: {last, or[CHANNELS-1:0], data[CHANNELS*BIT_WIDTH-1:0]}
    function automatic int entry_width(input int channels, input int bit_width);
        return channels * (bit_width + 1) + 1;
    endfunction

endpackage

// File: rtl/adc_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; pointers carry an extra
// wrap bit so full and empty are distinguished without a counter.
module adc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // Full is judged before any same-cycle pop, so a push into a full FIFO is lost.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Head is masked while empty so the stream shows zeros instead of stale data.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Multi-channel ADC capture controller: input pipeline, armed/triggered
// decimated capture, overrange tracking and a FWFT valid/ready output stream.
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int BIT_WIDTH   = 14,
    parameter int CHANNELS    = 2,
    parameter int FIFO_DEPTH  = 16,
    parameter int CNT_WIDTH   = 16,
    parameter int DECIM_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS*BIT_WIDTH-1:0] adc_data,
    input  logic [CHANNELS-1:0]           adc_or,
    output logic                          adc_enable_n,
    input  logic                          arm,
    input  logic                          trig,
    input  logic                          abort,
    input  logic [CNT_WIDTH-1:0]          n_samples,
    input  logic [DECIM_WIDTH-1:0]        decim,
    input  logic                          or_clear,
    output logic                          busy,
    output logic                          done,
    output logic [CHANNELS-1:0]           or_sticky,
    output logic                          overflow,
    output logic [CHANNELS*BIT_WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]           out_or,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int DW = CHANNELS * BIT_WIDTH;
    localparam int EW = entry_width(CHANNELS, BIT_WIDTH);

    logic [DW-1:0]          s1_data_q, s2_data_q;
    logic [CHANNELS-1:0]    s1_or_q, s2_or_q;
    logic                   en_n_q;
    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   n_samples_q, n_samples_d;
    logic [CNT_WIDTH-1:0]   sample_cnt_q, sample_cnt_d;
    logic [DECIM_WIDTH-1:0] decim_q, decim_d;
    logic [DECIM_WIDTH-1:0] decim_cnt_q, decim_cnt_d;
    logic [CHANNELS-1:0]    or_sticky_q, or_sticky_d;
    logic                   overflow_q, overflow_d;
    logic                   done_q, done_d;
    logic                   last_dropped_q, last_dropped_d;

    logic                   keep, is_last;
    logic                   fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic                   push_last;
    logic [EW-1:0]          fifo_head;

    assign keep    = (state_q == CAPTURE) && (decim_cnt_q == '0) && !abort;
    assign is_last = (sample_cnt_q == n_samples_q - CNT_WIDTH'(1));

    always_comb begin
        state_d        = state_q;
        n_samples_d    = n_samples_q;
        decim_d        = decim_q;
        sample_cnt_d   = sample_cnt_q;
        decim_cnt_d    = decim_cnt_q;
        last_dropped_d = last_dropped_q;
        done_d         = 1'b0;
        fifo_push      = 1'b0;
        fifo_flush     = 1'b0;
        push_last      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (arm && n_samples != '0) begin
                    n_samples_d  = n_samples;
                    decim_d      = decim;
                    sample_cnt_d = '0;
                    decim_cnt_d  = '0;
                    state_d      = ARMED;
                end
            end
            ARMED: begin
                if (trig) state_d = CAPTURE;
            end
            CAPTURE: begin
                decim_cnt_d = (decim_cnt_q == decim_q) ? '0 : decim_cnt_q + DECIM_WIDTH'(1);
                if (keep) begin
                    sample_cnt_d = sample_cnt_q + CNT_WIDTH'(1);
                    fifo_push    = 1'b1;
                    push_last    = is_last;
                    if (is_last) begin
                        last_dropped_d = fifo_full;
                        state_d        = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // A dropped final sample never reaches the head, so drain to empty instead.
                if (last_dropped_q ? fifo_empty : (fifo_pop && fifo_head[EW-1])) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d    = IDLE;
            fifo_flush = 1'b1;
            fifo_push  = 1'b0;
            done_d     = 1'b0;
        end

        // A set event in the same cycle as or_clear wins.
        or_sticky_d = (or_clear ? '0 : or_sticky_q) | (keep ? s2_or_q : '0);
        overflow_d  = (or_clear ? 1'b0 : overflow_q) | (keep && fifo_full);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_data_q      <= '0;
            s2_data_q      <= '0;
            s1_or_q        <= '0;
            s2_or_q        <= '0;
            en_n_q         <= 1'b1;
            state_q        <= IDLE;
            n_samples_q    <= '0;
            decim_q        <= '0;
            sample_cnt_q   <= '0;
            decim_cnt_q    <= '0;
            or_sticky_q    <= '0;
            overflow_q     <= 1'b0;
            done_q         <= 1'b0;
            last_dropped_q <= 1'b0;
        end else begin
            s1_data_q      <= adc_data;
            s2_data_q      <= s1_data_q;
            s1_or_q        <= adc_or;
            s2_or_q        <= s1_or_q;
            en_n_q         <= 1'b0;
            state_q        <= state_d;
            n_samples_q    <= n_samples_d;
            decim_q        <= decim_d;
            sample_cnt_q   <= sample_cnt_d;
            decim_cnt_q    <= decim_cnt_d;
            or_sticky_q    <= or_sticky_d;
            overflow_q     <= overflow_d;
            done_q         <= done_d;
            last_dropped_q <= last_dropped_d;
        end
    end

    adc_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (fifo_flush),
        .push    (fifo_push),
        .wr_data ({push_last, s2_or_q, s2_data_q}),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign fifo_pop     = out_valid && out_ready;
    assign out_valid    = !fifo_empty;
    assign out_last     = fifo_head[EW-1];
    assign out_or       = fifo_head[DW +: CHANNELS];
    assign out_data     = fifo_head[DW-1:0];
    assign adc_enable_n = en_n_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign or_sticky    = or_sticky_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scoreboard bench for adc_capture_ctrl: a ramp on adc_data lets every captured
// sample be predicted from the cycle number it was presented on the pins.
module tb_adc_capture_ctrl;

    localparam int BW  = 14;
    localparam int CH  = 2;
    localparam int FD  = 4;
    localparam int CW  = 16;
    localparam int DCW = 8;
    localparam int DW  = CH * BW;
    localparam int EW  = CH * (BW + 1) + 1;
    localparam int OW  = 1 + 1 + 1 + CH + 1 + 1 + 1 + CH + DW;
    localparam logic [OW-1:0] RST_OUTS = {1'b1, {(OW-1){1'b0}}};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] adc_data = '0;
    logic [CH-1:0] adc_or = '0;
    logic          adc_enable_n;
    logic          arm = 1'b0, trig = 1'b0, abort = 1'b0, or_clear = 1'b0;
    logic [CW-1:0] n_samples = '0;
    logic [DCW-1:0] decim = '0;
    logic          busy, done, overflow, out_last, out_valid;
    logic          out_ready = 1'b0;
    logic [CH-1:0] or_sticky, out_or;
    logic [DW-1:0] out_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int pop_cnt = 0;
    logic [CH-1:0] or_hist [4096];
    logic [EW-1:0] exp_q [$];

    adc_capture_ctrl #(
        .BIT_WIDTH(BW), .CHANNELS(CH), .FIFO_DEPTH(FD),
        .CNT_WIDTH(CW), .DECIM_WIDTH(DCW)
    ) dut (
        .clk(clk), .rst(rst), .adc_data(adc_data), .adc_or(adc_or),
        .adc_enable_n(adc_enable_n), .arm(arm), .trig(trig), .abort(abort),
        .n_samples(n_samples), .decim(decim), .or_clear(or_clear),
        .busy(busy), .done(done), .or_sticky(or_sticky), .overflow(overflow),
        .out_data(out_data), .out_or(out_or), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Pin ramp: during cycle k channel 0 carries k and channel 1 carries k+1000.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1 adc_data = {BW'(cyc + 1000), BW'(cyc)};
        end
    end

    function automatic logic [EW-1:0] exp_entry(input int c, input logic last);
        return {last, or_hist[c % 4096], BW'(c + 1000), BW'(c)};
    endfunction

    function automatic logic [OW-1:0] outs();
        return {adc_enable_n, busy, done, or_sticky, overflow,
                out_valid, out_last, out_or, out_data};
    endfunction

    // Stream and done monitor, sampled on the falling edge.
    initial begin
        logic [EW-1:0] exp;
        logic prev_busy;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid && out_ready) begin
                    pop_cnt++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL stream_unexpected: got last=%b or=%b data=%h, required no output",
                                 out_last, out_or, out_data);
                    end else begin
                        exp = exp_q.pop_front();
                        if ({out_last, out_or, out_data} !== exp) begin
                            errors++;
                            $display("FAIL stream_entry: got %h, required %h",
                                     {out_last, out_or, out_data}, exp);
                        end
                    end
                end
                if (done) begin
                    done_cnt++;
                    checks++;
                    if (busy !== 1'b0 || prev_busy !== 1'b1) begin
                        errors++;
                        $display("FAIL done_busy: busy=%b prev_busy=%b at done, required 0 and 1",
                                 busy, prev_busy);
                    end
                end
                prev_busy = busy;
            end else begin
                prev_busy = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic start_capture(input int n, input int d, output int t);
        step();
        arm = 1'b1; n_samples = CW'(n); decim = DCW'(d);
        step();
        arm = 1'b0;
        step();
        trig = 1'b1;
        t = cyc;
        step();
        trig = 1'b0;
    endtask

    // Sample 0 is the pin value from the cycle before trig was presented.
    task automatic push_exp(input int t, input int n, input int d, input int max_store);
        for (int i = 0; i < n && i < max_store; i++)
            exp_q.push_back(exp_entry(t - 1 + i * (d + 1), i == n - 1));
    endtask

    task automatic wait_done(input int start, input string name);
        int k;
        k = 0;
        while (done_cnt == start && k < 300) begin
            @(negedge clk);
            #1;
            k++;
        end
        checks++;
        if (done_cnt == start) begin
            errors++;
            $display("FAIL %s_done_timeout: done count %0d, required %0d", name, done_cnt, start + 1);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing: %0d expected samples not delivered, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (outs() !== RST_OUTS) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required %h", outs(), RST_OUTS);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (adc_enable_n !== 1'b1) begin
            errors++;
            $display("FAIL enable_before_clock: got %b, required 1", adc_enable_n);
        end
        @(posedge clk);
        #1;
        checks++;
        if (adc_enable_n !== 1'b0) begin
            errors++;
            $display("FAIL enable_after_clock: got %b, required 0", adc_enable_n);
        end
    endtask

    task automatic test_ramp();
        int t, d0;
        out_ready = 1'b1;
        d0 = done_cnt;
        start_capture(4, 0, t);
        push_exp(t, 4, 0, 99);
        wait_done(d0, "ramp");
        check_drained("ramp");
        repeat (5) step();
        checks++;
        if (done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL ramp_done_once: got %0d pulses, required 1", done_cnt - d0);
        end
    endtask

    task automatic test_decim();
        int t, d0;
        d0 = done_cnt;
        start_capture(3, 2, t);
        push_exp(t, 3, 2, 99);
        wait_done(d0, "decim");
        check_drained("decim");
    endtask

    task automatic test_overflow();
        int t, d0, p0;
        out_ready = 1'b0;
        d0 = done_cnt;
        start_capture(6, 0, t);
        push_exp(t, 6, 0, FD);
        repeat (10) step();
        checks++;
        if ({out_valid, overflow, busy} !== 3'b111) begin
            errors++;
            $display("FAIL overflow_hold: valid/overflow/busy=%b, required 111",
                     {out_valid, overflow, busy});
        end
        p0 = pop_cnt;
        out_ready = 1'b1;
        wait_done(d0, "overflow");
        check_drained("overflow");
        checks++;
        if (pop_cnt - p0 != FD) begin
            errors++;
            $display("FAIL overflow_count: got %0d samples, required %0d", pop_cnt - p0, FD);
        end
        or_clear = 1'b1;
        step();
        or_clear = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear: got %b, required 0", overflow);
        end
    endtask

    task automatic test_overrange();
        int t, d0;
        out_ready = 1'b1;
        d0 = done_cnt;
        start_capture(4, 0, t);
        adc_or = 2'b10;
        or_hist[(t + 1) % 4096] = 2'b10;
        push_exp(t, 4, 0, 99);
        step();
        adc_or = 2'b00;
        wait_done(d0, "or");
        check_drained("or");
        checks++;
        if (or_sticky !== 2'b10) begin
            errors++;
            $display("FAIL or_sticky_set: got %b, required 10", or_sticky);
        end
        or_clear = 1'b1;
        step();
        or_clear = 1'b0;
        checks++;
        if (or_sticky !== 2'b00) begin
            errors++;
            $display("FAIL or_clear_alone: got %b, required 00", or_sticky);
        end
        // Second capture: or_clear lands on the same edge the overrange sample is kept.
        d0 = done_cnt;
        start_capture(4, 0, t);
        adc_or = 2'b10;
        or_hist[(t + 1) % 4096] = 2'b10;
        push_exp(t, 4, 0, 99);
        step();
        adc_or = 2'b00;
        step();
        or_clear = 1'b1;
        step();
        or_clear = 1'b0;
        checks++;
        if (or_sticky !== 2'b10) begin
            errors++;
            $display("FAIL or_clear_vs_set: got %b, required 10", or_sticky);
        end
        wait_done(d0, "or2");
        check_drained("or2");
        or_clear = 1'b1;
        step();
        or_clear = 1'b0;
        checks++;
        if (or_sticky !== 2'b00) begin
            errors++;
            $display("FAIL or_clear_again: got %b, required 00", or_sticky);
        end
    endtask

    task automatic test_abort();
        int t, d0;
        out_ready = 1'b0;
        d0 = done_cnt;
        start_capture(8, 0, t);
        step();
        step();
        step();
        abort = 1'b1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre_valid: got %b, required 1", out_valid);
        end
        step();
        abort = 1'b0;
        checks++;
        if ({busy, out_valid, done} !== 3'b000) begin
            errors++;
            $display("FAIL abort_state: busy/valid/done=%b, required 000", {busy, out_valid, done});
        end
        repeat (5) step();
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d pulses, required 0", done_cnt - d0);
        end
        out_ready = 1'b1;
        start_capture(2, 0, t);
        push_exp(t, 2, 0, 99);
        wait_done(d0, "post_abort");
        check_drained("post_abort");
    endtask

    task automatic test_reset_drain();
        int t;
        out_ready = 1'b0;
        start_capture(3, 0, t);
        repeat (4) step();
        checks++;
        if ({busy, out_valid} !== 2'b11) begin
            errors++;
            $display("FAIL drain_pre: busy/valid=%b, required 11", {busy, out_valid});
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (outs() !== RST_OUTS) begin
            errors++;
            $display("FAIL async_reset: got %h, required %h", outs(), RST_OUTS);
        end
        @(posedge clk);
        #1;
        checks++;
        if (outs() !== RST_OUTS) begin
            errors++;
            $display("FAIL reset_hold: got %h, required %h", outs(), RST_OUTS);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        checks++;
        if ({adc_enable_n, busy, out_valid} !== 3'b000) begin
            errors++;
            $display("FAIL post_reset: en_n/busy/valid=%b, required 000",
                     {adc_enable_n, busy, out_valid});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) or_hist[i] = '0;
        test_reset();
        test_ramp();
        test_decim();
        test_overflow();
        test_overrange();
        test_abort();
        test_reset_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_capture_ctrl.md
# adc_capture_ctrl

Parametrised multi-channel capture controller for the AD9648-class dual ADC front end. It double-registers CHANNELS parallel sample buses and tracks per-channel overrange. On an armed trigger it captures a programmed number of decimated samples. It hands them downstream through a valid/ready stream buffered by a small synchronous FIFO. It sits between the ADC pins and the acquisition/transfer logic, all in the single ADC sample-clock domain.

## Interface
- BIT_WIDTH, 14, sample width per channel
- CHANNELS, 2, number of ADC channels (1..8)
- FIFO_DEPTH, 16, output FIFO entries, power of two ≥ 4
- CNT_WIDTH, 16, width of the sample-count register
- DECIM_WIDTH, 8, width of the decimation factor

- clk  in  1  ADC sample clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- adc_data  in  CHANNELS*BIT_WIDTH  raw ADC buses, channel 0 in LSBs
- adc_or  in  CHANNELS  raw overrange pins
- adc_enable_n  out  1  ADC enable to the chip, active low
- arm  in  1  single-cycle pulse, arms a capture
- trig  in  1  trigger, level-sampled while ARMED
- abort  in  1  single-cycle pulse, returns to IDLE
- n_samples  in  CNT_WIDTH  samples per capture, latched on arm
- decim  in  DECIM_WIDTH  keep 1 of every decim+1 samples, latched on arm
- or_clear  in  1  clears or_sticky and overflow
- busy  out  1  high in ARMED, CAPTURE or DRAIN
- done  out  1  one-cycle pulse when the last sample leaves the FIFO
- or_sticky  out  CHANNELS  per-channel sticky overrange, set during CAPTURE
- overflow  out  1  sticky: a sample was dropped because the FIFO was full
- out_data  out  CHANNELS*BIT_WIDTH  stream data
- out_or  out  CHANNELS  overrange bits accompanying out_data
- out_last  out  1  marks the final sample of a capture
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready

## Operation
- Input pipeline: two register stages on adc_data and adc_or, so each sample is delayed by 2 cycles. The pipeline runs every cycle regardless of state.
- adc_enable_n is 0 in every state except under reset.
- States:
  - IDLE: on arm with n_samples≠0, latch n_samples and decim, clear the sample and decimation counters, go to ARMED. An arm with n_samples=0 is ignored.
  - ARMED: on trig=1, go to CAPTURE. The sample at pipeline stage 2 in the cycle after trig is seen becomes sample 0.
  - CAPTURE: the decimation counter counts 0..decim. When it is 0, the current stage-2 sample is "kept": the sample counter increments and the sample is written to the FIFO if the FIFO is not full. If the FIFO is full, the sample is dropped, overflow is set, and the sample still counts. The kept sample with count = n_samples−1 is tagged last, and the state goes to DRAIN in the same cycle.
  - DRAIN: wait for a FIFO pop of the entry tagged last, then pulse done and go to IDLE. If the last sample was dropped, go to IDLE with done once the FIFO is empty.
- abort in any state: go to IDLE and flush the FIFO; done is not pulsed. abort has priority over arm, trig and completion in the same cycle.
- arm outside IDLE is ignored.
- or_sticky[i] is set when a kept sample has or=1.
- When or_clear coincides with a set event, the set wins.
- FIFO entry is {last, or[CHANNELS-1:0], data}. First-word fall-through: out_valid = !empty, and out_data, out_or and out_last are the head entry. A pop happens when out_valid && out_ready.
- Simultaneous push and pop on a full FIFO is not allowed. Full is evaluated before the pop, and the sample is dropped.

## Timing
- Reset values:
  - adc_enable_n=1 under reset, 0 from the first clock after reset deasserts.
  - busy=0, done=0, or_sticky=0, overflow=0, out_valid=0, out_last=0, out_data=0, out_or=0.
  - FIFO empty, state IDLE.
- Latency is 2 cycles from an ADC pin to the input-pipeline stage-2 register. A sample kept in cycle t is visible at the FIFO head with out_valid=1 in cycle t+1 if the FIFO was empty.
- done asserts in the cycle after the final pop.
- With decim=0, every cycle is kept. With decim=k, kept samples are spaced k+1 cycles apart.
- Reset mid-capture discards all state and FIFO contents immediately.

## Structure
- Package adc_capture_pkg holds the state enum (IDLE, ARMED, CAPTURE, DRAIN) and the FIFO entry width function CHANNELS*(BIT_WIDTH+1)+1.
- Sub-module adc_sync_fifo: parametrised width and depth, FWFT, with flush input, full and empty outputs. It uses pointers one bit wider than the address.

## Test plan
- CHANNELS=2, n_samples=4, decim=0, out_ready=1, ramp on adc_data:
  - 4 consecutive ramp values appear, starting at the first stage-2 value after trig.
  - out_last is set on the 4th.
  - done pulses once, and busy falls in the same cycle as done.
- decim=2, n_samples=3:
  - Output holds ramp values r, r+3, r+6.
  - out_last is set on r+6.
- FIFO_DEPTH=4, out_ready=0, n_samples=6:
  - 4 entries are held and overflow=1.
  - After out_ready=1, exactly 4 samples are delivered with no out_last.
  - done is still pulsed when the FIFO is empty.
- adc_or[1] pulsed during capture:
  - or_sticky=2'b10 and the matching out_or bit is set.
  - or_clear asserted in the same cycle as a new overrange leaves the bit set.
  - or_clear alone clears it.
- abort during CAPTURE with 3 entries queued:
  - Next cycle: state IDLE, out_valid=0, no done.
  - A subsequent arm works normally.
- Reset asserted mid-DRAIN, asynchronously between clock edges:
  - All outputs go to reset values without waiting for a clock edge.
  - adc_enable_n=1 during reset.
